muldiv_sequencer: RTL

- Multi-cycle RV32M execute unit alongside the single-cycle EX-stage ALU.
- Decode flags M-extension ops (Opcode 0110011, Funct7 0000001) and raises start with Funct3 and forwarded operands.
- The block holds the pipeline via stall, runs an iterative shift-add multiply or restoring divide, then presents the result for one cycle with done.
- Sign handling, divide-by-zero and signed overflow follow the RISC-V M spec.

---
 rtl/muldiv_sequencer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// ----------------
// Multi-cycle RV32M execute unit sitting next to the single-cycle EX ALU.
// Multiplies with an iterative shift-add over a 2*XLEN accumulator and
// divides with a restoring algorithm over the same accumulator
// ({remainder, quotient}). Signs are stripped in PREP and restored in FIX.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   M-op present in EX; only looked at while IDLE
//   funct3  in   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                100 DIV 101 DIVU 110 REM 111 REMU
//   op_a    in   rs1 value (multiplicand / dividend)
//   op_b    in   rs2 value (multiplier / divisor)
//   flush   in   squash; abandons the current operation, result untouched
//   stall   out  hold IF/ID/EX while the unit is busy
//   done    out  one-cycle pulse, result valid this cycle
//   result  out  last completed value, held until the next one completes
//
// Handshake: an op is accepted on a rising edge where the unit is IDLE,
// start=1 and flush=0. stall is high from that accept cycle until the
// cycle before done; in the done cycle stall is low so the pipeline
// advances and captures result on that same edge. The next start is
// expected in the IDLE cycle that follows. start in any other state is
// ignored. flush always sends the unit back to IDLE; a done pulse already
// being shown in the DONE cycle is not withdrawn.

module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST_IT = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched instruction and working registers
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   mcand_q;   // multiplicand (MUL) or divisor magnitude (DIV)
  logic [2*XLEN-1:0] acc_q;     // product, or {remainder, quotient}
  logic              neg_q;     // negate product / quotient in FIX
  logic              neg_r_q;   // negate remainder in FIX (dividend sign)
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   result_q;

  // ---------------------------------------------------------------------
  // Operand decode (valid while the latched instruction is in PREP)
  // ---------------------------------------------------------------------
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_val;

  always_comb begin
    is_div   = f3_q[2];
    // DIV/REM have funct3[0]=0; MULH is 01, MULHSU is 10 in funct3[1:0].
    a_signed = is_div ? ~f3_q[0] : (f3_q[1:0] == 2'b01 || f3_q[1:0] == 2'b10);
    b_signed = is_div ? ~f3_q[0] : (f3_q[1:0] == 2'b01);
    a_neg    = a_signed & a_q[XLEN-1];
    b_neg    = b_signed & b_q[XLEN-1];
    a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag    = b_neg ? (~b_q + 1'b1) : b_q;

    div_zero = is_div && (b_q == '0);
    div_ovf  = is_div && ~f3_q[0] && (a_q == MIN_NEG) && (b_q == '1);
    special  = div_zero | div_ovf;

    // funct3[1] selects remainder-type ops.
    if (div_zero) special_val = f3_q[1] ? a_q : '1;
    else          special_val = f3_q[1] ? '0  : a_q;
  end

  // ---------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;   // remainder shifted left with next dividend bit
  logic              div_fits;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    // Shift-add: upper half accumulates, multiplier drains out of the low half.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: trial subtract, keep it only when it does not go
    // negative. The remainder is always below the divisor afterwards, so
    // the XLEN-bit difference is exact when it is kept.
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_fits  = (div_shift >= {1'b0, mcand_q});
    div_rem   = div_fits ? (div_shift[XLEN-1:0] - mcand_q) : div_shift[XLEN-1:0];
    div_next  = {div_rem, acc_q[XLEN-2:0], div_fits};
  end

  // ---------------------------------------------------------------------
  // Sign restore and result select
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo      = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    if (is_div) begin
      if (f3_q[1]) fix_val = neg_r_q ? (~rem + 1'b1) : rem;
      else         fix_val = neg_q   ? (~quo + 1'b1) : quo;
    end else begin
      fix_val = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = start;
        if (start) state_d = S_PREP;
      end
      S_PREP: begin
        stall   = 1'b1;
        state_d = special ? S_DONE : S_RUN;
      end
      S_RUN: begin
        stall = 1'b1;
        if (cnt_q == LAST_IT) state_d = S_FIX;
      end
      S_FIX: begin
        stall   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Squash overrides everything, including a start seen in IDLE.
    if (flush) state_d = S_IDLE;
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            f3_q <= funct3;
            a_q  <= op_a;
            b_q  <= op_b;
          end
        end
        S_PREP: begin
          neg_q   <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
          cnt_q   <= '0;
          if (special) begin
            if (!flush) result_q <= special_val;
          end else if (is_div) begin
            acc_q   <= {{XLEN{1'b0}}, a_mag};
            mcand_q <= b_mag;
          end else begin
            acc_q   <= {{XLEN{1'b0}}, b_mag};
            mcand_q <= a_mag;
          end
        end
        S_RUN: begin
          acc_q <= is_div ? div_next : mul_next;
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX: begin
          if (!flush) result_q <= fix_val;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule
